// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and the slave models that talk to it.
//   apb_state_e   : requester bus phase (IDLE / SETUP / ACCESS)
//   APB_*         : default bus geometry, byte-lane bit count and CRC lane index
//   crc_xor()     : XOR of the enabled data bytes below the CRC lane
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int unsigned APB_LANE_BITS  = $clog2(APB_STRB_WIDTH);
  localparam int unsigned APB_CRC_LANE   = APB_STRB_WIDTH - 1;

  // Widest bus the helper accepts; callers zero-extend into this width.
  localparam int unsigned CRC_MAX_LANES  = 64;

  // XOR of bytes 0..lanes-2 whose strobe bit is set; the top lane carries the CRC itself.
  function automatic logic [7:0] crc_xor(input logic [CRC_MAX_LANES*8-1:0] data,
                                         input logic [CRC_MAX_LANES-1:0]   strb,
                                         input int unsigned                lanes);
    logic [7:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < CRC_MAX_LANES; i++) begin
      if ((i + 1 < lanes) && strb[i]) acc ^= data[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between the requester and a CRC-protected memory slave.
//   master modport: drives PADDR/PPROT/PSELx/PENABLE/PWRITE/PWDATA/PSTRB/PWAKEUP,
//                   samples PREADY/PSLVERR/PRDATA
//   slave modport : the mirror image
interface apb_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0]            PPROT;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PWAKEUP;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_crc_xor.sv
// Combinational strobe-masked XOR reducer over the bytes below the CRC lane.
//   data : bus word (top byte ignored)
//   strb : lane enables (top bit ignored)
//   crc  : XOR of the enabled lower bytes
module apb_crc_xor
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [7:0]            crc
);
  logic [CRC_MAX_LANES*8-1:0] data_ext;
  logic [CRC_MAX_LANES-1:0]   strb_ext;

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = data;
    strb_ext                 = '0;
    strb_ext[STRB_WIDTH-1:0] = strb;
    crc                      = crc_xor(data_ext, strb_ext, STRB_WIDTH);
  end
endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, one APB transfer out, one response back.
//   PCLK, PRESETn            : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/strb : command stream
//   rsp_valid/ready/rdata/slverr/crcerr/timeout : response stream (held until consumed)
//   apb                      : APB bus (master modport)
// Writes get the CRC byte and PPROT filled in; reads have their CRC byte checked.
// Transfers whose slave never raises PREADY are aborted after TIMEOUT wait cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_crcerr,
  output logic                  rsp_timeout,
  apb_master_if.master          apb
);
  localparam int unsigned LANE_BITS = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST       = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LANE_MASK = ADDR_WIDTH'((1 << LANE_BITS) - 1);
  localparam logic [STRB_WIDTH-1:0] CRC_LANE_STRB  = STRB_WIDTH'(1) << (STRB_WIDTH - 1);
  localparam logic [STRB_WIDTH-1:0] ALL_LANES      = '1;

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  accept, complete, timeout_hit;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            pprot_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;

  logic                  rsp_valid_q, rsp_slverr_q, rsp_crcerr_q, rsp_timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [7:0]            wr_crc, rd_crc;
  logic                  rd_crc_bad;

  assign addr_aligned = cmd_addr & ~ADDR_LANE_MASK;

  apb_crc_xor #(.DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wr_crc (
    .data (cmd_wdata),
    .strb (cmd_strb),
    .crc  (wr_crc)
  );

  apb_crc_xor #(.DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rd_crc (
    .data (apb.PRDATA),
    .strb (ALL_LANES),
    .crc  (rd_crc)
  );

  assign rd_crc_bad = (apb.PRDATA[DATA_WIDTH-1 -: 8] != rd_crc);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    // Reset gating keeps cmd_ready low while PRESETn is asserted.
    cmd_ready   = PRESETn
               && ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && apb.PREADY))
               && (!rsp_valid_q || rsp_ready);
    accept      = cmd_valid && cmd_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.PREADY) begin
          complete = 1'b1;
          state_d  = accept ? ST_SETUP : ST_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          // This wait cycle is the TIMEOUT-th one: abort instead of counting further.
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) wait_cnt_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (accept) begin
      paddr_q  <= addr_aligned;
      pprot_q  <= addr_aligned[ADDR_WIDTH-1 -: 3];
      pwrite_q <= cmd_write;
      if (cmd_write) begin
        pwdata_q <= {wr_crc, cmd_wdata[DATA_WIDTH-9:0]};
        pstrb_q  <= cmd_strb | CRC_LANE_STRB;
      end else begin
        pstrb_q  <= '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_crcerr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (complete) begin
      rsp_valid_q   <= 1'b1;
      rsp_slverr_q  <= apb.PSLVERR;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= pwrite_q ? '0 : apb.PRDATA;
      rsp_crcerr_q  <= !pwrite_q && rd_crc_bad;
    end else if (timeout_hit) begin
      rsp_valid_q   <= 1'b1;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b1;
      rsp_rdata_q   <= '0;
      rsp_crcerr_q  <= 1'b0;
    end else if (rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_crcerr  = rsp_crcerr_q;
  assign rsp_timeout = rsp_timeout_q;

  assign apb.PADDR   = paddr_q;
  assign apb.PPROT   = pprot_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PSELx   = (state_q != ST_IDLE);
  assign apb.PENABLE = (state_q == ST_ACCESS);
  assign apb.PWAKEUP = PRESETn && (cmd_valid || (state_q != ST_IDLE));

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_crcerr, rsp_timeout;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_pwdata;

  apb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) apb_bus ();

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_crcerr  (rsp_crcerr),
    .rsp_timeout (rsp_timeout),
    .apb         (apb_bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned waits;     // ACCESS cycles with PREADY low before PREADY rises
    logic [31:0] prdata;
    logic        pslverr;
    int unsigned hold;      // cycles the response is back-pressured
    logic [7:0]  e_paddr;
    logic [2:0]  e_pprot;
    logic [31:0] e_pwdata;
    logic [3:0]  e_pstrb;
    logic [31:0] e_rdata;
    logic        e_slverr;
    logic        e_crcerr;
    logic        e_timeout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected bus fields and response from the transfer rules, byte by byte.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [7:0]  crc;
    int unsigned a;
    r = v;
    a = v.addr;
    r.e_paddr = 8'(a - a % (1 << APB_LANE_BITS));
    r.e_pprot = 3'(r.e_paddr / 32);
    if (v.write) begin
      crc = 8'h00;
      for (int i = 0; i < APB_CRC_LANE; i++)
        if (v.strb[i]) crc ^= 8'(v.wdata >> (8 * i));
      r.e_pwdata = {crc, v.wdata[23:0]};
      r.e_pstrb  = v.strb | 4'b1000;
    end else begin
      r.e_pwdata = last_pwdata;
      r.e_pstrb  = 4'b0000;
    end
    if (v.waits >= TO) begin
      r.e_timeout = 1'b1;
      r.e_slverr  = 1'b0;
      r.e_rdata   = 32'h0;
      r.e_crcerr  = 1'b0;
    end else begin
      r.e_timeout = 1'b0;
      r.e_slverr  = v.pslverr;
      r.e_rdata   = v.write ? 32'h0 : v.prdata;
      r.e_crcerr  = !v.write &&
                    (8'(v.prdata >> 24) != (8'(v.prdata) ^ 8'(v.prdata >> 8) ^ 8'(v.prdata >> 16)));
    end
    return r;
  endfunction

  task automatic do_xfer(input vec_t v);
    int n;
    int k;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb; rsp_ready = 1'b0;
    apb_bus.PREADY = 1'b0; apb_bus.PSLVERR = 1'b0;
    #1;
    chk("pwakeup_cmd", apb_bus.PWAKEUP, 1);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK); #1; n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    #1;
    chk("setup_psel",    apb_bus.PSELx,   1);
    chk("setup_penable", apb_bus.PENABLE, 0);
    chk("setup_paddr",   apb_bus.PADDR,   v.e_paddr);
    chk("setup_pprot",   apb_bus.PPROT,   v.e_pprot);
    chk("setup_pwrite",  apb_bus.PWRITE,  v.write);
    chk("setup_pwdata",  apb_bus.PWDATA,  v.e_pwdata);
    chk("setup_pstrb",   apb_bus.PSTRB,   v.e_pstrb);
    chk("setup_rsp_valid", rsp_valid, 0);
    for (k = 0; k <= int'(TO); k++) begin
      @(negedge PCLK);
      if (v.e_timeout && k == int'(TO)) break;
      apb_bus.PREADY  = (k == int'(v.waits));
      apb_bus.PSLVERR = v.pslverr;
      apb_bus.PRDATA  = (k == int'(v.waits)) ? v.prdata : $urandom;
      #1;
      chk("access_psel",    apb_bus.PSELx,   1);
      chk("access_penable", apb_bus.PENABLE, 1);
      chk("access_paddr",   apb_bus.PADDR,   v.e_paddr);
      chk("access_pwdata",  apb_bus.PWDATA,  v.e_pwdata);
      chk("access_rsp_valid", rsp_valid, 0);
      if (k == int'(v.waits)) break;
    end
    if (!v.e_timeout) @(negedge PCLK);
    apb_bus.PREADY = 1'b0; apb_bus.PSLVERR = 1'b0;
    #1;
    chk("done_psel",     apb_bus.PSELx,   0);
    chk("done_penable",  apb_bus.PENABLE, 0);
    chk("rsp_valid",     rsp_valid,   1);
    chk("rsp_rdata",     rsp_rdata,   v.e_rdata);
    chk("rsp_slverr",    rsp_slverr,  v.e_slverr);
    chk("rsp_crcerr",    rsp_crcerr,  v.e_crcerr);
    chk("rsp_timeout",   rsp_timeout, v.e_timeout);
    for (int unsigned h = 0; h < v.hold; h++) begin
      @(negedge PCLK); #1;
      chk("hold_valid",   rsp_valid,   1);
      chk("hold_rdata",   rsp_rdata,   v.e_rdata);
      chk("hold_timeout", rsp_timeout, v.e_timeout);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_consumed", rsp_valid, 0);
  endtask

  vec_t tbl [9];
  vec_t rv;
  logic [31:0] pd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // write addr wdata strb waits prdata slverr hold | paddr pprot pwdata pstrb | rdata slverr crcerr timeout
    tbl[0] = '{1'b1, 8'h05, 32'h00040201, 4'b0011, 0,  32'h00000000, 1'b0, 1, 8'h04, 3'd0, 32'h03040201, 4'b1011, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hA7, 32'h00000000, 4'b0000, 0,  32'h1A345678, 1'b0, 0, 8'hA4, 3'd5, 32'h03040201, 4'b0000, 32'h1A345678, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h10, 32'h00000000, 4'b0000, 3,  32'h07040201, 1'b0, 2, 8'h10, 3'd0, 32'h03040201, 4'b0000, 32'h07040201, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h33, 32'h00000000, 4'b0000, 1,  32'h00040201, 1'b1, 0, 8'h30, 3'd1, 32'h03040201, 4'b0000, 32'h00040201, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 32'h55BBCCDD, 4'b1111, 2,  32'h00000000, 1'b1, 0, 8'hFC, 3'd7, 32'hAABBCCDD, 4'b1111, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h40, 32'hFF00FF00, 4'b0000, 0,  32'h00000000, 1'b0, 0, 8'h40, 3'd2, 32'h0000FF00, 4'b1000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h08, 32'h00000000, 4'b0000, 15, 32'h00000000, 1'b0, 0, 8'h08, 3'd0, 32'h0000FF00, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h0C, 32'h00000000, 4'b0000, 99, 32'h12345678, 1'b1, 1, 8'h0C, 3'd0, 32'h0000FF00, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h20, 32'h00000011, 4'b0001, 0,  32'h00000000, 1'b0, 0, 8'h20, 3'd1, 32'h11000011, 4'b1001, 32'h00000000, 1'b0, 1'b0, 1'b0};

    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFF;
    cmd_wdata = 32'hFFFFFFFF; cmd_strb = 4'hF; rsp_ready = 1'b0;
    apb_bus.PREADY = 1'b1; apb_bus.PSLVERR = 1'b1; apb_bus.PRDATA = 32'h0;
    last_pwdata = 32'h0;
    #2;
    chk("rst_cmd_ready", cmd_ready,        0);
    chk("rst_pwakeup",   apb_bus.PWAKEUP,  0);
    chk("rst_psel",      apb_bus.PSELx,    0);
    chk("rst_penable",   apb_bus.PENABLE,  0);
    chk("rst_paddr",     apb_bus.PADDR,    0);
    chk("rst_pwdata",    apb_bus.PWDATA,   0);
    chk("rst_pstrb",     apb_bus.PSTRB,    0);
    chk("rst_rsp_valid", rsp_valid,        0);
    repeat (2) @(negedge PCLK);
    cmd_valid = 1'b0; apb_bus.PREADY = 1'b0; apb_bus.PSLVERR = 1'b0;
    PRESETn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_xfer(tbl[i]);
      if (tbl[i].write) last_pwdata = tbl[i].e_pwdata;
    end

    // Back-to-back: write then read with no IDLE gap between them.
    @(negedge PCLK);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h14;
    cmd_wdata = 32'h00000005; cmd_strb = 4'b0001; apb_bus.PREADY = 1'b0;
    #1;
    chk("b2b_ready_a", cmd_ready, 1);
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_addr = 8'h2A; cmd_wdata = 32'h0; cmd_strb = 4'b0;
    #1;
    chk("b2b_setup_a_psel",    apb_bus.PSELx,   1);
    chk("b2b_setup_a_penable", apb_bus.PENABLE, 0);
    chk("b2b_setup_a_ready",   cmd_ready,       0);
    @(negedge PCLK);
    apb_bus.PREADY = 1'b1; apb_bus.PSLVERR = 1'b0;
    #1;
    chk("b2b_access_a_penable", apb_bus.PENABLE, 1);
    chk("b2b_access_a_ready",   cmd_ready,       1);
    @(negedge PCLK);
    cmd_valid = 1'b0; apb_bus.PREADY = 1'b0;
    #1;
    chk("b2b_setup_b_psel",    apb_bus.PSELx,   1);
    chk("b2b_setup_b_penable", apb_bus.PENABLE, 0);
    chk("b2b_setup_b_paddr",   apb_bus.PADDR,   8'h28);
    chk("b2b_setup_b_pwrite",  apb_bus.PWRITE,  0);
    chk("b2b_setup_b_pstrb",   apb_bus.PSTRB,   0);
    chk("b2b_setup_b_pwdata",  apb_bus.PWDATA,  32'h05000005);
    chk("b2b_rsp_a_valid",     rsp_valid,       1);
    chk("b2b_rsp_a_rdata",     rsp_rdata,       0);
    @(negedge PCLK);
    apb_bus.PREADY = 1'b1; apb_bus.PRDATA = 32'h03020100;
    #1;
    chk("b2b_access_b_psel",    apb_bus.PSELx,   1);
    chk("b2b_access_b_penable", apb_bus.PENABLE, 1);
    chk("b2b_rsp_a_consumed",   rsp_valid,       0);
    @(negedge PCLK);
    apb_bus.PREADY = 1'b0;
    #1;
    chk("b2b_idle_psel",   apb_bus.PSELx, 0);
    chk("b2b_rsp_b_valid", rsp_valid,     1);
    chk("b2b_rsp_b_rdata", rsp_rdata,     32'h03020100);
    chk("b2b_rsp_b_crc",   rsp_crcerr,    0);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    #1;
    chk("b2b_rsp_b_consumed", rsp_valid, 0);
    last_pwdata = 32'h05000005;

    // Reset pulled mid-ACCESS: everything clears at once and no response appears.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    #1;
    chk("mid_rst_in_access", apb_bus.PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel",      apb_bus.PSELx,   0);
    chk("mid_rst_penable",   apb_bus.PENABLE, 0);
    chk("mid_rst_paddr",     apb_bus.PADDR,   0);
    chk("mid_rst_pprot",     apb_bus.PPROT,   0);
    chk("mid_rst_pwdata",    apb_bus.PWDATA,  0);
    chk("mid_rst_cmd_ready", cmd_ready,       0);
    chk("mid_rst_rsp_valid", rsp_valid,       0);
    @(negedge PCLK);
    PRESETn = 1'b1; apb_bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      chk("post_rst_rsp_valid", rsp_valid,     0);
      chk("post_rst_psel",      apb_bus.PSELx, 0);
    end
    apb_bus.PREADY = 1'b0;
    last_pwdata = 32'h0;

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv.write   = 1'($urandom_range(0, 1));
      rv.addr    = 8'($urandom);
      rv.wdata   = $urandom;
      rv.strb    = 4'($urandom);
      rv.waits   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 1);
      pd         = $urandom;
      if ($urandom_range(0, 1) == 1) pd[31:24] = pd[7:0] ^ pd[15:8] ^ pd[23:16];
      rv.prdata  = pd;
      rv.pslverr = ($urandom_range(0, 3) == 0);
      rv.hold    = $urandom_range(0, 2);
      rv = model(rv);
      do_xfer(rv);
      if (rv.write) last_pwdata = rv.e_pwdata;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
